// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller for the 5-stage core.
// Combines load-use bubbles, memory-stage bus waits and taken jumps into a
// single stall vector plus a front-end flush, watchdogs bus waits into a
// sticky error state and keeps saturating stall/bubble event counters.
module pipe_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inst_is_load_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_raddr_i,
    input  logic [4:0]           rs2_raddr_i,
    input  logic                 rs1_re_i,
    input  logic                 rs2_re_i,
    input  logic                 jump_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ack_i,
    output logic [5:0]           stall_o,
    output logic                 flush_o,
    output logic                 bus_err_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Last wait-count value before the watchdog fires.
    localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

    // Stall vector encodings (bit k = hold stage k).
    localparam logic [5:0] STALL_ALL  = 6'b111111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t               r_state;
    logic [15:0]          r_wcnt;
    logic                 r_bus_err;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;

    logic                 w_load_use;
    logic                 w_mem_stall;
    logic                 w_is_err;
    logic                 w_bubble;
    logic [5:0]           w_stall;

    // Hazard detection and priority-encoded stall/flush selection.
    always_comb begin
        w_is_err    = (r_state == ST_ERR);
        w_load_use  = inst_is_load_i && (rd_i != 5'd0) &&
                      ((rs1_re_i && (rs1_raddr_i == rd_i)) ||
                       (rs2_re_i && (rs2_raddr_i == rd_i)));
        w_mem_stall = mem_req_i && !mem_ack_i && !w_is_err;
        w_bubble    = 1'b0;
        w_stall     = STALL_NONE;
        if (w_is_err) begin
            w_stall = STALL_ALL;
        end else if (w_mem_stall) begin
            w_stall = STALL_MEM;
        end else if (jump_i) begin
            // The ID instruction is on the wrong path, so no bubble is needed.
            w_stall = STALL_NONE;
        end else if (w_load_use) begin
            w_stall  = STALL_LU;
            w_bubble = 1'b1;
        end
    end

    // A jump held behind a memory stall flushes only once the stall clears.
    assign stall_o = w_stall;
    assign flush_o = jump_i && !w_mem_stall && !w_is_err;

    // Bus-wait watchdog FSM with registered sticky error output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= 16'd0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_req_i && !mem_ack_i) begin
                        r_state <= ST_WAIT;
                        r_wcnt  <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i || !mem_req_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_wcnt == WCNT_LAST) begin
                        r_state   <= ST_ERR;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
                ST_ERR: begin
                    r_bus_err <= 1'b1;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_err <= 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters for stall cycles and inserted bubbles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if ((w_stall != STALL_NONE) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign bus_err_o    = r_bus_err;
    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed testbench for pipe_ctrl (TIMEOUT=4, CNT_WIDTH=4).
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, registered outputs on the following falling edge.
module tb_pipe_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          inst_is_load_i = 1'b0;
    logic [4:0]    rd_i = 5'd0;
    logic [4:0]    rs1_raddr_i = 5'd0;
    logic [4:0]    rs2_raddr_i = 5'd0;
    logic          rs1_re_i = 1'b0;
    logic          rs2_re_i = 1'b0;
    logic          jump_i = 1'b0;
    logic          mem_req_i = 1'b0;
    logic          mem_ack_i = 1'b0;
    logic [5:0]    stall_o;
    logic          flush_o;
    logic          bus_err_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inst_is_load_i(inst_is_load_i),
        .rd_i          (rd_i),
        .rs1_raddr_i   (rs1_raddr_i),
        .rs2_raddr_i   (rs2_raddr_i),
        .rs1_re_i      (rs1_re_i),
        .rs2_re_i      (rs2_re_i),
        .jump_i        (jump_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .bus_err_o     (bus_err_o),
        .stall_cnt_o   (stall_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        inst_is_load_i = 1'b0;
        rd_i = 5'd0;
        rs1_raddr_i = 5'd0;
        rs2_raddr_i = 5'd0;
        rs1_re_i = 1'b0;
        rs2_re_i = 1'b0;
        jump_i = 1'b0;
        mem_req_i = 1'b0;
        mem_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL reset_stall got %b exp 000000", stall_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush_o); end
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b exp 0", bus_err_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt_o); end
        checks++; if (bubble_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_bubble_cnt got %0d exp 0", bubble_cnt_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        // rs1 match
        @(negedge clk_i);
        inst_is_load_i = 1'b1; rd_i = 5'd5; rs1_re_i = 1'b1; rs1_raddr_i = 5'd5;
        #1;
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL lu_rs1_stall got %b exp 000111", stall_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL lu_rs1_flush got %b exp 0", flush_o); end
        @(negedge clk_i);
        idle_inputs();
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL lu_after_stall got %b exp 000000", stall_o); end
        checks++; if (bubble_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_bubble_cnt got %0d exp 1", bubble_cnt_o); end
        checks++; if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt_o); end
        // rd = x0 never hazards
        @(negedge clk_i);
        inst_is_load_i = 1'b1; rd_i = 5'd0; rs1_re_i = 1'b1; rs1_raddr_i = 5'd0;
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL lu_rd0_stall got %b exp 000000", stall_o); end
        // read enable low
        @(negedge clk_i);
        inst_is_load_i = 1'b1; rd_i = 5'd5; rs1_re_i = 1'b0; rs1_raddr_i = 5'd5;
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL lu_re0_stall got %b exp 000000", stall_o); end
        // not a load
        @(negedge clk_i);
        inst_is_load_i = 1'b0; rd_i = 5'd5; rs1_re_i = 1'b1; rs1_raddr_i = 5'd5;
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL lu_noload_stall got %b exp 000000", stall_o); end
        // rs2 match
        @(negedge clk_i);
        inst_is_load_i = 1'b1; rd_i = 5'd7; rs1_re_i = 1'b1; rs1_raddr_i = 5'd3;
        rs2_re_i = 1'b1; rs2_raddr_i = 5'd7;
        #1;
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL lu_rs2_stall got %b exp 000111", stall_o); end
        @(negedge clk_i);
        idle_inputs();
        #1;
        checks++; if (bubble_cnt_o !== 4'd2) begin errors++; $display("FAIL lu_bubble_cnt2 got %0d exp 2", bubble_cnt_o); end
        checks++; if (stall_cnt_o !== 4'd2) begin errors++; $display("FAIL lu_stall_cnt2 got %0d exp 2", stall_cnt_o); end
    endtask

    task automatic test_bus_wait();
        do_reset();
        @(negedge clk_i);
        mem_req_i = 1'b1; mem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall_o !== 6'b011111) begin errors++; $display("FAIL bus_wait_stall[%0d] got %b exp 011111", i, stall_o); end
            @(negedge clk_i);
        end
        mem_ack_i = 1'b1;
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL bus_ack_stall got %b exp 000000", stall_o); end
        @(negedge clk_i);
        idle_inputs();
        #1;
        checks++; if (stall_cnt_o !== 4'd3) begin errors++; $display("FAIL bus_stall_cnt got %0d exp 3", stall_cnt_o); end
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL bus_wait_err got %b exp 0", bus_err_o); end
        checks++; if (bubble_cnt_o !== 4'd0) begin errors++; $display("FAIL bus_bubble_cnt got %0d exp 0", bubble_cnt_o); end
        // ack in the same cycle as the request costs nothing
        @(negedge clk_i);
        mem_req_i = 1'b1; mem_ack_i = 1'b1;
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL bus_zero_wait_stall got %b exp 000000", stall_o); end
        @(negedge clk_i);
        idle_inputs();
        #1;
        checks++; if (stall_cnt_o !== 4'd3) begin errors++; $display("FAIL bus_zero_wait_cnt got %0d exp 3", stall_cnt_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk_i);
        mem_req_i = 1'b1; mem_ack_i = 1'b0;
        // cycles 0..TO: no error yet, memory stall encoding
        for (int i = 0; i <= TO; i++) begin
            #1;
            checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL to_err_early[%0d] got %b exp 0", i, bus_err_o); end
            checks++; if (stall_o !== 6'b011111) begin errors++; $display("FAIL to_stall_wait[%0d] got %b exp 011111", i, stall_o); end
            @(negedge clk_i);
        end
        // cycle TO+1: error
        #1;
        checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL to_err_set got %b exp 1", bus_err_o); end
        checks++; if (stall_o !== 6'b111111) begin errors++; $display("FAIL to_stall_err got %b exp 111111", stall_o); end
        @(negedge clk_i);
        mem_req_i = 1'b0; jump_i = 1'b1;
        #1;
        checks++; if (stall_o !== 6'b111111) begin errors++; $display("FAIL to_stall_sticky got %b exp 111111", stall_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL to_flush_err got %b exp 0", flush_o); end
        checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %b exp 1", bus_err_o); end
        checks++; if (stall_cnt_o !== 4'd6) begin errors++; $display("FAIL to_stall_cnt got %0d exp 6", stall_cnt_o); end
        jump_i = 1'b0;
        // asynchronous reset pulse away from any clock edge
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL to_rst_err got %b exp 0", bus_err_o); end
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL to_rst_stall got %b exp 000000", stall_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL to_rst_stall_cnt got %0d exp 0", stall_cnt_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL to_rst_flush got %b exp 0", flush_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL to_post_rst_stall got %b exp 000000", stall_o); end
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL to_post_rst_err got %b exp 0", bus_err_o); end
    endtask

    task automatic test_jump();
        do_reset();
        // jump beats load-use
        @(negedge clk_i);
        jump_i = 1'b1;
        inst_is_load_i = 1'b1; rd_i = 5'd9; rs1_re_i = 1'b1; rs1_raddr_i = 5'd9;
        #1;
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL jmp_lu_flush got %b exp 1", flush_o); end
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL jmp_lu_stall got %b exp 000000", stall_o); end
        @(negedge clk_i);
        idle_inputs();
        #1;
        checks++; if (bubble_cnt_o !== 4'd0) begin errors++; $display("FAIL jmp_bubble_cnt got %0d exp 0", bubble_cnt_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL jmp_stall_cnt got %0d exp 0", stall_cnt_o); end
        // jump deferred behind a memory stall
        @(negedge clk_i);
        jump_i = 1'b1; mem_req_i = 1'b1; mem_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL jmp_mem_flush[%0d] got %b exp 0", i, flush_o); end
            checks++; if (stall_o !== 6'b011111) begin errors++; $display("FAIL jmp_mem_stall[%0d] got %b exp 011111", i, stall_o); end
            @(negedge clk_i);
        end
        mem_ack_i = 1'b1;
        #1;
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL jmp_ack_flush got %b exp 1", flush_o); end
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL jmp_ack_stall got %b exp 000000", stall_o); end
        @(negedge clk_i);
        idle_inputs();
        #1;
        checks++; if (stall_cnt_o !== 4'd2) begin errors++; $display("FAIL jmp_mem_stall_cnt got %0d exp 2", stall_cnt_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL jmp_idle_flush got %b exp 0", flush_o); end
    endtask

    task automatic test_withdraw();
        do_reset();
        @(negedge clk_i);
        mem_req_i = 1'b1; mem_ack_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++; if (stall_o !== 6'b011111) begin errors++; $display("FAIL wd_wait_stall got %b exp 011111", stall_o); end
        @(negedge clk_i);
        mem_req_i = 1'b0;
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL wd_drop_stall got %b exp 000000", stall_o); end
        for (int i = 0; i < TO + 2; i++) begin
            @(negedge clk_i);
            #1;
            checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL wd_no_err[%0d] got %b exp 0", i, bus_err_o); end
        end
        // a fresh request gets the full timeout budget again
        @(negedge clk_i);
        mem_req_i = 1'b1;
        for (int i = 0; i <= TO; i++) begin
            @(negedge clk_i);
            #1;
            if (i < TO) begin
                checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL wd_fresh_err[%0d] got %b exp 0", i, bus_err_o); end
            end else begin
                checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL wd_fresh_timeout got %b exp 1", bus_err_o); end
            end
        end
        checks++; if (stall_cnt_o !== 4'd7) begin errors++; $display("FAIL wd_stall_cnt got %0d exp 7", stall_cnt_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk_i);
        inst_is_load_i = 1'b1; rd_i = 5'd12; rs2_re_i = 1'b1; rs2_raddr_i = 5'd12;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (i == 10) begin
                #1;
                checks++; if (bubble_cnt_o !== 4'd11) begin errors++; $display("FAIL sat_mid_bubble got %0d exp 11", bubble_cnt_o); end
            end
        end
        #1;
        checks++; if (bubble_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_bubble got %0h exp f", bubble_cnt_o); end
        checks++; if (stall_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_stall got %0h exp f", stall_cnt_o); end
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL sat_stall_vec got %b exp 000111", stall_o); end
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        #1;
        checks++; if (bubble_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_hold_bubble got %0h exp f", bubble_cnt_o); end
        checks++; if (stall_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_hold_stall got %0h exp f", stall_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_bus_wait();
        test_timeout();
        test_jump();
        test_withdraw();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
